// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage: forwarding, immediate extension,
// load-use bubble insertion and a saturating bubble counter.
module alu_operand_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int IMM_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [IMM_WIDTH-1:0]      imm,
  input  logic [1:0]                imm_mode,
  input  logic                      alu_src,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr,
  input  logic [DATA_WIDTH-1:0]     ex_wr_data,
  input  logic                      mem_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic [DATA_WIDTH-1:0]     op_a,
  output logic [DATA_WIDTH-1:0]     op_b,
  output logic [DATA_WIDTH-1:0]     store_data,
  output logic                      out_valid,
  output logic                      hazard,
  output logic [CNT_WIDTH-1:0]      hazard_count
);

  localparam int PAD = DATA_WIDTH - IMM_WIDTH;

  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;
  logic [DATA_WIDTH-1:0] sext_imm;
  logic [DATA_WIDTH-1:0] ext_imm;
  logic [DATA_WIDTH-1:0] op_b_next;
  logic                  ex_fwd_ok;

  // A load in EX has no result yet, so it can never be a forwarding source.
  assign ex_fwd_ok = ex_wr_en && !ex_is_load;

  always_comb begin
    fwd_rs1 = rs1_data;
    if (rs1_addr != '0) begin
      if (ex_fwd_ok && ex_wr_addr == rs1_addr)
        fwd_rs1 = ex_wr_data;
      else if (mem_wr_en && mem_wr_addr == rs1_addr)
        fwd_rs1 = mem_wr_data;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data;
    if (rs2_addr != '0) begin
      if (ex_fwd_ok && ex_wr_addr == rs2_addr)
        fwd_rs2 = ex_wr_data;
      else if (mem_wr_en && mem_wr_addr == rs2_addr)
        fwd_rs2 = mem_wr_data;
    end
  end

  assign sext_imm = {{PAD{imm[IMM_WIDTH-1]}}, imm};

  always_comb begin
    ext_imm = sext_imm;
    case (imm_mode)
      2'b00:   ext_imm = sext_imm;
      2'b01:   ext_imm = {{PAD{1'b0}}, imm};
      2'b10:   ext_imm = {imm, {PAD{1'b0}}};
      default: ext_imm = {sext_imm[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  assign op_b_next = alu_src ? ext_imm : fwd_rs2;

  assign hazard = in_valid && ex_wr_en && ex_is_load && (ex_wr_addr != '0) &&
                  ((ex_wr_addr == rs1_addr) || ((ex_wr_addr == rs2_addr) && !alu_src));

  // Stall freezes everything; flush and bubble only clear the valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a         <= '0;
      op_b         <= '0;
      store_data   <= '0;
      out_valid    <= 1'b0;
      hazard_count <= '0;
    end else if (stall) begin
      op_a         <= op_a;
    end else if (flush) begin
      out_valid    <= 1'b0;
    end else if (hazard) begin
      out_valid    <= 1'b0;
      if (hazard_count != '1)
        hazard_count <= hazard_count + 1'b1;
    end else begin
      op_a         <= fwd_rs1;
      op_b         <= op_b_next;
      store_data   <= fwd_rs2;
      out_valid    <= in_valid;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed cases plus randomized
// traffic compared against an arithmetic reference model.
module tb_alu_operand_stage;

  localparam int DW  = 16;
  localparam int IW  = 4;
  localparam int AW  = 4;
  localparam int CW  = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, stall, flush, alu_src;
  logic [AW-1:0] rs1_addr, rs2_addr, ex_wr_addr, mem_wr_addr;
  logic [DW-1:0] rs1_data, rs2_data, ex_wr_data, mem_wr_data;
  logic [IW-1:0] imm;
  logic [1:0]    imm_mode;
  logic          ex_wr_en, ex_is_load, mem_wr_en;
  logic [DW-1:0] op_a, op_b, store_data;
  logic          out_valid, hazard;
  logic [CW-1:0] hazard_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int m_op_a, m_op_b, m_store, m_count;
  bit m_valid;

  alu_operand_stage #(
    .DATA_WIDTH(DW), .IMM_WIDTH(IW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .imm_mode(imm_mode), .alu_src(alu_src),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .out_valid(out_valid),
    .hazard(hazard), .hazard_count(hazard_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_fwd(input int addr, input int data);
    if (addr == 0) return data;
    if (ex_wr_en && !ex_is_load && ex_wr_addr == addr) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == addr) return mem_wr_data;
    return data;
  endfunction

  function automatic int model_ext(input int raw, input int mode);
    int sv;
    sv = (raw >= (1 << (IW - 1))) ? raw - (1 << IW) : raw;
    case (mode)
      0:       return sv & 32'hFFFF;
      1:       return raw;
      2:       return (raw << (DW - IW)) & 32'hFFFF;
      default: return (sv * 2) & 32'hFFFF;
    endcase
  endfunction

  function automatic bit model_hazard();
    return in_valid && ex_wr_en && ex_is_load && ex_wr_addr != 0 &&
           (ex_wr_addr == rs1_addr || (ex_wr_addr == rs2_addr && !alu_src));
  endfunction

  // One clock: check the combinational hazard, advance the model, check outputs.
  task automatic applyStimulus();
    bit hz;
    #1;
    hz = model_hazard();
    checkOutput("hazard", {31'b0, hazard}, {31'b0, hz});
    if (rst) begin
      m_op_a = 0; m_op_b = 0; m_store = 0; m_valid = 0; m_count = 0;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (flush) begin
      m_valid = 0;
    end else if (hz) begin
      m_valid = 0;
      if (m_count < CNT_MAX) m_count++;
    end else begin
      m_op_a  = model_fwd(rs1_addr, rs1_data);
      m_store = model_fwd(rs2_addr, rs2_data);
      m_op_b  = alu_src ? model_ext(imm, imm_mode) : m_store;
      m_valid = in_valid;
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    checkOutput("hazard_count", {29'b0, hazard_count}, m_count);
    if (m_valid) begin
      checkOutput("op_a", {16'b0, op_a}, m_op_a);
      checkOutput("op_b", {16'b0, op_b}, m_op_b);
      checkOutput("store_data", {16'b0, store_data}, m_store);
    end
  endtask

  task automatic quiet();
    rst = 0; in_valid = 1; stall = 0; flush = 0; alu_src = 0;
    rs1_addr = 1; rs2_addr = 2; rs1_data = 16'h0101; rs2_data = 16'h0202;
    imm = 0; imm_mode = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
  endtask

  logic [DW-1:0] imm_table [4];

  initial begin
    imm_table[0] = 16'hFFFA; imm_table[1] = 16'h000A;
    imm_table[2] = 16'hA000; imm_table[3] = 16'hFFF4;
    m_op_a = 0; m_op_b = 0; m_store = 0; m_valid = 0; m_count = 0;

    quiet();
    rst = 1;
    applyStimulus();
    checkOutput("reset_op_a", {16'b0, op_a}, 0);
    checkOutput("reset_op_b", {16'b0, op_b}, 0);
    checkOutput("reset_store", {16'b0, store_data}, 0);

    // Immediate modes
    quiet(); alu_src = 1; imm = 4'hA;
    for (int m = 0; m < 4; m++) begin
      imm_mode = m[1:0];
      applyStimulus();
      checkOutput("imm_mode_op_b", {16'b0, op_b}, {16'b0, imm_table[m]});
      checkOutput("imm_mode_valid", {31'b0, out_valid}, 1);
    end

    // Forwarding priority
    quiet(); rs1_addr = 3; rs1_data = 16'h0001;
    ex_wr_en = 1; ex_wr_addr = 3; ex_wr_data = 16'h1234;
    mem_wr_en = 1; mem_wr_addr = 3; mem_wr_data = 16'h5678;
    applyStimulus();
    checkOutput("fwd_ex", {16'b0, op_a}, 32'h1234);
    ex_wr_en = 0;
    applyStimulus();
    checkOutput("fwd_mem", {16'b0, op_a}, 32'h5678);
    rs1_addr = 0; ex_wr_en = 1; ex_wr_addr = 0; mem_wr_addr = 0;
    applyStimulus();
    checkOutput("fwd_r0", {16'b0, op_a}, 32'h0001);

    // Load-use hazard
    quiet(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5; rs2_addr = 5;
    applyStimulus();
    checkOutput("loaduse_valid", {31'b0, out_valid}, 0);
    checkOutput("loaduse_count", {29'b0, hazard_count}, 1);
    alu_src = 1;
    applyStimulus();
    checkOutput("loaduse_imm_valid", {31'b0, out_valid}, 1);

    // Stall and flush
    quiet(); rs1_addr = 0; rs1_data = 16'h0011;
    applyStimulus();
    stall = 1; flush = 1; rs1_data = 16'h7777; rs1_addr = 4;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stall_op_a", {16'b0, op_a}, 32'h0011);
      checkOutput("stall_valid", {31'b0, out_valid}, 1);
    end
    stall = 0;
    applyStimulus();
    checkOutput("flush_valid", {31'b0, out_valid}, 0);

    // Mid-stream reset
    quiet();
    applyStimulus();
    rst = 1;
    applyStimulus();
    checkOutput("midrst_valid", {31'b0, out_valid}, 0);
    checkOutput("midrst_op_a", {16'b0, op_a}, 0);
    checkOutput("midrst_count", {29'b0, hazard_count}, 0);

    // Counter saturation
    quiet(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 1;
    for (int i = 0; i < CNT_MAX + 3; i++) applyStimulus();
    checkOutput("saturate", {29'b0, hazard_count}, CNT_MAX);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 149) == 0);
      stall       = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      in_valid    = ($urandom_range(0, 5) != 0);
      alu_src     = $urandom_range(0, 1);
      rs1_addr    = $urandom_range(0, 3);
      rs2_addr    = $urandom_range(0, 3);
      rs1_data    = $urandom;
      rs2_data    = $urandom;
      imm         = $urandom;
      imm_mode    = $urandom;
      ex_wr_en    = $urandom_range(0, 1);
      ex_is_load  = ($urandom_range(0, 3) == 0);
      ex_wr_addr  = $urandom_range(0, 3);
      ex_wr_data  = $urandom;
      mem_wr_en   = $urandom_range(0, 1);
      mem_wr_addr = $urandom_range(0, 3);
      mem_wr_data = $urandom;
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
